// File: rtl/rf_vector_player_if.sv
// rf_vector_player_if: vector ROM port plus register-file/ALU datapath port.
// master = player side, slave = ROM/datapath side.
interface rf_vector_player_if #(
  parameter int AW = 14
);
  logic [AW-1:0] vec_addr;
  logic [120:0]  vec_data;
  logic [4:0]    rd_addr1;
  logic [4:0]    rd_addr2;
  logic [4:0]    wr_addr;
  logic [4:0]    shamt;
  logic [3:0]    funct;
  logic          RegWrite;
  logic [31:0]   rd_data1;
  logic [31:0]   rd_data2;
  logic [31:0]   wr_data;

  modport master (
    output vec_addr, rd_addr1, rd_addr2, wr_addr,
    output shamt, funct, RegWrite,
    input  vec_data, rd_data1, rd_data2, wr_data
  );

  modport slave (
    input  vec_addr, rd_addr1, rd_addr2, wr_addr,
    input  shamt, funct, RegWrite,
    output vec_data, rd_data1, rd_data2, wr_data
  );
endinterface

// File: rtl/rf_vector_player.sv
// rf_vector_player: replays ROM vectors into the RF/ALU datapath and grades it.
// Optional macro VEC_STOP_ON_FAIL_EN: end the run at the first mismatch.
module rf_vector_player #(
  parameter int NUM_VEC = 10000,
  parameter int AW      = $clog2(NUM_VEC),
  parameter int CW      = $clog2(NUM_VEC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  rf_vector_player_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       pass_cnt,
  output logic [CW-1:0]       fail_cnt,
  output logic [AW-1:0]       first_fail_idx
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, CHECK, DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] idx;
  logic [4:0]    ra1_q;
  logic [4:0]    ra2_q;
  logic [4:0]    wa_q;
  logic [4:0]    sh_q;
  logic [3:0]    fn_q;
  logic          rw_q;
  logic [31:0]   e1_q;
  logic [31:0]   e2_q;
  logic [31:0]   ew_q;
  logic          match;
  logic          last;
  logic          stop;
  logic          go;

  assign match = (bus.rd_data1 == e1_q)
              && (bus.rd_data2 == e2_q)
              && (bus.wr_data  == ew_q);
  assign last  = (idx == AW'(NUM_VEC - 1));
  assign go    = start && (state == IDLE || state == DONE);

`ifdef VEC_STOP_ON_FAIL_EN
  assign stop = last || !match;
`else
  assign stop = last;
`endif

  assign bus.vec_addr = idx;
  assign bus.rd_addr1 = ra1_q;
  assign bus.rd_addr2 = ra2_q;
  assign bus.wr_addr  = wa_q;
  assign bus.shamt    = sh_q;
  assign bus.funct    = fn_q;
  // write enable only while the stimulus has been stable a full cycle
  assign bus.RegWrite = (state == CHECK) && rw_q;
  assign busy = (state == FETCH) || (state == LATCH)
             || (state == CHECK);
  assign done = (state == DONE);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   state_nx = LATCH;
      LATCH:   state_nx = CHECK;
      CHECK:   state_nx = stop ? DONE : FETCH;
      DONE:    if (start) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
  end

  // vector index, stimulus/expected latches and result counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx            <= '0;
      ra1_q          <= '0;
      ra2_q          <= '0;
      wa_q           <= '0;
      sh_q           <= '0;
      fn_q           <= '0;
      rw_q           <= 1'b0;
      e1_q           <= '0;
      e2_q           <= '0;
      ew_q           <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
    end else begin
      if (go) begin
        idx            <= '0;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        first_fail_idx <= '0;
      end
      if (state == LATCH) begin
        ra1_q <= bus.vec_data[120:116];
        ra2_q <= bus.vec_data[115:111];
        wa_q  <= bus.vec_data[110:106];
        sh_q  <= bus.vec_data[105:101];
        fn_q  <= bus.vec_data[100:97];
        rw_q  <= bus.vec_data[96];
        e1_q  <= bus.vec_data[95:64];
        e2_q  <= bus.vec_data[63:32];
        ew_q  <= bus.vec_data[31:0];
      end
      if (state == CHECK) begin
        if (match) begin
          pass_cnt <= pass_cnt + CW'(1);
        end else begin
          fail_cnt <= fail_cnt + CW'(1);
          if (fail_cnt == '0) first_fail_idx <= idx;
        end
        if (!stop) idx <= idx + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_vector_player.sv
// tb_rf_vector_player: directed vectors against a behavioural RF/ALU model.
// Expected run results are queued at start and graded when done rises.
module tb_rf_vector_player;
  localparam int NV = 4;
  localparam int AW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic [AW-1:0] first_fail_idx;

  rf_vector_player_if #(.AW(AW)) bus ();

  rf_vector_player #(
    .NUM_VEC(NV), .AW(AW), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus),
    .busy(busy),
    .done(done),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // synchronous vector ROM
  logic [120:0] rom [NV];
  always @(posedge clk) bus.vec_data <= rom[bus.vec_addr];

  // register file model, r0 hardwired zero, ri = i after datapath reset
  logic        dp_rst_n = 1'b0;
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (!dp_rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else if (bus.RegWrite && bus.wr_addr != 5'd0) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  function automatic logic [31:0] alu(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [4:0]  sh,
                                      input logic [3:0]  fn);
    case (fn)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return $unsigned($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  assign bus.rd_data1 = (bus.rd_addr1 == 5'd0) ? 32'd0 : regs[bus.rd_addr1];
  assign bus.rd_data2 = (bus.rd_addr2 == 5'd0) ? 32'd0 : regs[bus.rd_addr2];
  assign bus.wr_data  = alu(bus.rd_data1, bus.rd_data2,
                            bus.shamt, bus.funct);

  function automatic logic [120:0] mk(
    input logic [4:0] a1, input logic [4:0] a2,
    input logic [4:0] wa, input logic [4:0] sh,
    input logic [3:0] fn, input logic rw,
    input logic [31:0] e1, input logic [31:0] e2,
    input logic [31:0] ew);
    return {a1, a2, wa, sh, fn, rw, e1, e2, ew};
  endfunction

  // v0: r3 = r8+r8 = 0x10 ; v1: r3<<4 (reads v0 write)
  // v2: r6 = r5-r3 = -11 ; v3: r6^r7 (reads v2 write)
  task automatic load_base();
    rom[0] = mk(8, 8, 3, 0, 0, 1, 32'h8, 32'h8, 32'h10);
    rom[1] = mk(3, 2, 5, 4, 5, 0, 32'h10, 32'h2, 32'h100);
    rom[2] = mk(5, 3, 6, 0, 1, 1, 32'h5, 32'h10, 32'hFFFF_FFF5);
    rom[3] = mk(6, 7, 9, 0, 4, 0, 32'hFFFF_FFF5, 32'h7,
                32'hFFFF_FFF2);
  endtask

  typedef struct {
    int pass_n;
    int fail_n;
    int first;
    int busy_n;
    int rw_n;
    int last_rd1;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   busy_n = 0;
  int   rw_n = 0;
  logic done_q = 1'b0;

  // monitor: grade each run when done rises
  always @(negedge clk) begin
    if (!rst) begin
      busy_n = 0;
      rw_n   = 0;
      done_q = 1'b0;
    end else begin
      if (busy) busy_n++;
      if (bus.RegWrite) rw_n++;
      if (done && !done_q) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("pass_cnt", 32'(pass_cnt), e.pass_n);
          chk("fail_cnt", 32'(fail_cnt), e.fail_n);
          chk("first_fail_idx", 32'(first_fail_idx), e.first);
          chk("run_cycles", busy_n, e.busy_n);
          chk("regwrite_cycles", rw_n, e.rw_n);
          chk("held_rd_addr1", 32'(bus.rd_addr1), e.last_rd1);
        end
        busy_n = 0;
        rw_n   = 0;
      end
      done_q = done;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_vec_addr"}, 32'(bus.vec_addr), 0);
    chk({tag, "_rd_addr1"}, 32'(bus.rd_addr1), 0);
    chk({tag, "_rd_addr2"}, 32'(bus.rd_addr2), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_shamt"}, 32'(bus.shamt), 0);
    chk({tag, "_funct"}, 32'(bus.funct), 0);
    chk({tag, "_regwrite"}, 32'(bus.RegWrite), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass_cnt), 0);
    chk({tag, "_fail"}, 32'(fail_cnt), 0);
    chk({tag, "_first"}, 32'(first_fail_idx), 0);
  endtask

  task automatic run(input exp_t x, input int poke);
    bit seen = 1'b0;
    q.push_back(x);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = (i == poke);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  exp_t good = '{4, 0, 0, 12, 2, 6};

  initial begin
    load_base();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    dp_rst_n = 1'b1;

    run(good, -1);

    // abort during vector 2, then restart from idx 0
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst_busy", 32'(busy), 0);
    run(good, -1);

    rom[2][31:0] = 32'hDEAD_BEEF;
`ifdef VEC_STOP_ON_FAIL_EN
    run('{2, 1, 2, 9, 2, 5}, -1);
`else
    run('{3, 1, 2, 12, 2, 6}, -1);
`endif
    load_base();

    // start pulsed during CHECK of vector 1
    run(good, 5);

    rom[1][63:32] = 32'h3;
    rom[3][63:32] = 32'h8;
`ifdef VEC_STOP_ON_FAIL_EN
    run('{1, 1, 1, 6, 1, 3}, -1);
`else
    run('{2, 2, 1, 12, 2, 6}, -1);
`endif
    load_base();

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_vector_player.md
# rf_vector_player

Synthesizable stimulus/check engine that replays stored test vectors into the register-file/ALU datapath (`TOP`) and grades its responses in hardware. It fetches one packed vector per step from a synchronous vector ROM, drives read/write addresses, shift amount, function code and write enable into the datapath, compares `rd_data1`/`rd_data2`/`wr_data` against expected values, and accumulates pass/fail counts. It sits beside `TOP` on the FPGA build, replacing the simulation bench for on-board regression.

## Interface
- `NUM_VEC`, 10000: number of vectors replayed per run (≥1).
- `AW`, `$clog2(NUM_VEC)`: vector ROM address width.
- `CW`, `$clog2(NUM_VEC+1)`: pass/fail counter width.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle run request; ignored while `busy`.
- `vec_addr`  out  AW  ROM address.
- `vec_data`  in  121  ROM word, valid the cycle after `vec_addr` is presented; fields [120:116] rd_addr1, [115:111] rd_addr2, [110:106] wr_addr, [105:101] shamt, [100:97] funct, [96] RegWrite, [95:64] exp rd_data1, [63:32] exp rd_data2, [31:0] exp wr_data.
- `rd_addr1`, `rd_addr2`, `wr_addr`, `shamt`  out  5 each  registered datapath stimulus.
- `funct`  out  4  registered ALU function.
- `RegWrite`  out  1  datapath write enable.
- `rd_data1`, `rd_data2`, `wr_data`  in  32 each  datapath responses (combinational in `TOP`).
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until next `start`.
- `pass_cnt`, `fail_cnt`  out  CW  result counters.
- `first_fail_idx`  out  AW  index of first failing vector; valid when `fail_cnt`≠0.

## Operation
- States: IDLE, FETCH, LATCH, CHECK, DONE.
- IDLE/DONE + `start`: clear counters, `first_fail_idx`, `done`; idx←0; → FETCH.
- FETCH: `vec_addr`=idx; → LATCH.
- LATCH: `vec_data` valid; at cycle end register all six stimulus fields onto outputs (`RegWrite` held 0); → CHECK.
- CHECK: stimulus stable for the whole cycle; `RegWrite` = vector bit. At cycle end compare all three responses with expected (exact 32-bit equality, all three must match). Match → `pass_cnt`+1; mismatch → `fail_cnt`+1, and if first failure `first_fail_idx`←idx. Datapath write commits on this same edge. If idx=NUM_VEC−1 → DONE, else idx+1 → FETCH.
- `RegWrite` is 1 only in CHECK: exactly one datapath write per vector with RegWrite=1.
- DONE: `done`=1, `busy`=0, outputs hold last stimulus, `RegWrite`=0.
- `start` during FETCH/LATCH/CHECK: ignored.
- Reset (any time, including mid-run): state IDLE, all outputs 0 (`vec_addr`, stimulus, `RegWrite`, `busy`, `done`, counters, `first_fail_idx`). Datapath reset is separate; run restarts only on new `start`.
- Invariant at DONE: `pass_cnt`+`fail_cnt` = NUM_VEC (without stop-on-fail).

## Timing
- 3 cycles per vector; run = 3·NUM_VEC cycles from the cycle after `start` to `done` rising.
- `busy` rises the cycle after `start`, falls with `done` rising.
- Response sampled at the rising edge ending CHECK, i.e. a full clock period after stimulus launch; datapath combinational path must meet one cycle.
- Read-after-write across vectors is observable: vector k+1's read sees vector k's write.

## Configuration
- `VEC_STOP_ON_FAIL_EN` defined: a mismatch in CHECK moves directly to DONE after updating counters; remaining vectors skipped, `pass_cnt`+`fail_cnt` = idx+1.
- Undefined: all NUM_VEC vectors always replayed regardless of failures.

## Test plan
- Reset mid-run (assert `rst` at vector 5 of 10): all outputs 0 next sample, state IDLE, `start` afterwards restarts from idx 0.
- NUM_VEC=4, all vectors match a model `TOP` -> `done` at 12 cycles after start, `pass_cnt`=4, `fail_cnt`=0.
- Vector 2 expected wr_data corrupted (0xDEADBEEF vs model) -> `fail_cnt`=1, `pass_cnt`=3, `first_fail_idx`=2.
- Vector 0 writes 0x0000_0010 to r3 (RegWrite=1), vector 1 reads r3 -> vector 1 passes with exp rd_data1=0x10; `RegWrite` observed high for exactly one cycle per vector.
- `start` pulsed during CHECK of vector 1 -> ignored, counters unaffected, single `done`.
- With `VEC_STOP_ON_FAIL_EN`, failures at vectors 1 and 3 of 4 -> DONE after vector 1, `fail_cnt`=1, `pass_cnt`=1, `first_fail_idx`=1.
